// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// Single-port data memory arbiter: core load/store (A) vs LCD reader (B), with per-read owner tracking.
// Latency: grant is combinational in the request cycle; read data and rvalid arrive MEM_LAT cycles after grant.
// Backpressure: the loser sees gnt=0 and must hold req/addr; nothing is queued, B is guarded against starvation.
module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 15,
    parameter int RR_MODE      = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  force_b,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_stall,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [15:0]           deny_cnt
);

    typedef struct packed {
        logic vld;
        logic own_b;
    } tag_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    tag_t                  tag_pipe [MEM_LAT];
    logic [7:0]            starve_cnt;
    logic                  last_a;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  a_win;
    logic                  b_win;
    logic                  rd_issue;

    always_comb begin
        a_win = 1'b0;
        b_win = 1'b0;
        if (rst_n) begin
            if (force_b) begin
                b_win = b_req;
            end else if (b_req && starve_cnt >= LIMIT) begin
                b_win = 1'b1;
            end else if (RR_MODE == 0) begin
                a_win = a_req;
                b_win = b_req & ~a_req;
            end else if (a_req && b_req) begin
                // Round robin: whoever was not served last goes now.
                a_win = ~last_a;
                b_win = last_a;
            end else begin
                a_win = a_req;
                b_win = b_req;
            end
        end
    end

    assign a_gnt       = a_win;
    assign b_gnt       = b_win;
    assign a_stall     = rst_n & a_req & ~a_win;
    assign mem_wren    = a_win & a_we;
    assign mem_address = a_win ? a_addr : (b_win ? b_addr : addr_q);
    assign mem_data    = a_win ? a_wdata : (b_win ? '0 : data_q);
    assign rd_issue    = b_win | (a_win & ~a_we);

    // Memory output is shared; the tag at the pipe tail says whose read it is.
    assign a_rdata  = mem_q;
    assign b_rdata  = mem_q;
    assign a_rvalid = tag_pipe[MEM_LAT-1].vld & ~tag_pipe[MEM_LAT-1].own_b;
    assign b_rvalid = tag_pipe[MEM_LAT-1].vld & tag_pipe[MEM_LAT-1].own_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LAT; i++) tag_pipe[i] <= '0;
            starve_cnt <= '0;
            last_a     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            deny_cnt   <= '0;
        end else begin
            tag_pipe[0] <= '{vld: rd_issue, own_b: b_win};
            for (int i = 1; i < MEM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
            if (a_win || b_win) begin
                addr_q <= mem_address;
                data_q <= mem_data;
                last_a <= a_win;
            end
            if (b_req && !b_win) begin
                if (starve_cnt != 8'hFF) starve_cnt <= starve_cnt + 8'd1;
            end else begin
                starve_cnt <= '0;
            end
            if (a_stall && deny_cnt != 16'hFFFF) deny_cnt <= deny_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// Bench for dmem_arbiter: u0 = MEM_LAT 1 / A-priority, u1 = MEM_LAT 2 / round robin, each with its own memory.
module tb_dmem_arbiter;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int LIMIT = 15;
    localparam int LAT0  = 1;
    localparam int LAT1  = 2;

    typedef struct packed {
        logic        force_b;
        logic        a_req;
        logic        a_we;
        logic [7:0]  a_addr;
        logic [31:0] a_wdata;
        logic        b_req;
        logic [7:0]  b_addr;
    } in_t;

    typedef struct packed {
        logic        a_gnt;
        logic        a_stall;
        logic        a_rvalid;
        logic [31:0] a_rdata;
        logic        b_gnt;
        logic        b_rvalid;
        logic [31:0] b_rdata;
        logic [7:0]  mem_address;
        logic [31:0] mem_data;
        logic        mem_wren;
        logic [15:0] deny_cnt;
    } out_t;

    typedef struct {
        int          inst;
        int          due;
        bit          own_b;
        logic [31:0] data;
    } ret_t;

    typedef struct {
        string       name;
        in_t         in;
        bit          a_gnt;
        bit          b_gnt;
        bit          wren;
        logic [7:0]  addr;
        bit          arv;
        bit          brv;
        logic [31:0] rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_ready = 1'b0;
    in_t  in0 = '0;
    in_t  in1 = '0;
    out_t o0, o1;

    logic        ag0, as0, arv0, bg0, brv0, mw0, ag1, as1, arv1, bg1, brv1, mw1;
    logic [31:0] ard0, brd0, md0, q0, ard1, brd1, md1, q1;
    logic [7:0]  ma0, ma1;
    logic [15:0] dc0, dc1;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LAT(LAT0), .STARVE_LIMIT(LIMIT), .RR_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .force_b(in0.force_b),
        .a_req(in0.a_req), .a_we(in0.a_we), .a_addr(in0.a_addr), .a_wdata(in0.a_wdata),
        .a_gnt(ag0), .a_stall(as0), .a_rvalid(arv0), .a_rdata(ard0),
        .b_req(in0.b_req), .b_addr(in0.b_addr), .b_gnt(bg0), .b_rvalid(brv0), .b_rdata(brd0),
        .mem_address(ma0), .mem_data(md0), .mem_wren(mw0), .mem_q(q0), .deny_cnt(dc0));

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LAT(LAT1), .STARVE_LIMIT(LIMIT), .RR_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .force_b(in1.force_b),
        .a_req(in1.a_req), .a_we(in1.a_we), .a_addr(in1.a_addr), .a_wdata(in1.a_wdata),
        .a_gnt(ag1), .a_stall(as1), .a_rvalid(arv1), .a_rdata(ard1),
        .b_req(in1.b_req), .b_addr(in1.b_addr), .b_gnt(bg1), .b_rvalid(brv1), .b_rdata(brd1),
        .mem_address(ma1), .mem_data(md1), .mem_wren(mw1), .mem_q(q1), .deny_cnt(dc1));

    assign o0 = {ag0, as0, arv0, ard0, bg0, brv0, brd0, ma0, md0, mw0, dc0};
    assign o1 = {ag1, as1, arv1, ard1, bg1, brv1, brd1, ma1, md1, mw1, dc1};

    function automatic logic [31:0] init_word(int k);
        return 32'h5A00_0000 ^ 32'(k * 32'h0001_0203);
    endfunction

    // Synchronous single-port memories: read data appears LATn cycles after the address cycle.
    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    logic [31:0] rp0;
    logic [31:0] rp1 [2];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < 256; k++) begin
                mem0[k] <= init_word(k);
                mem1[k] <= init_word(k);
            end
        end else begin
            if (mw0) mem0[ma0] <= md0;
            if (mw1) mem1[ma1] <= md1;
        end
        rp0    <= mem0[ma0];
        rp1[0] <= mem1[ma1];
        rp1[1] <= rp1[0];
    end
    assign q0 = rp0;
    assign q1 = rp1[1];

    // Reference model state
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          starve [2];
    int          deny [2];
    bit          last_a [2];
    logic [7:0]  hold_a [2];
    logic [31:0] hold_d [2];
    logic [31:0] shadow [2][256];
    bit          mg_a [2];
    bit          mg_b [2];
    ret_t        rq [$];
    vec_t        cur_vec;
    bit          vec_on = 1'b0;
    vec_t        tbl [8];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            starve[i] = 0;
            deny[i]   = 0;
            last_a[i] = 1'b0;
            hold_a[i] = '0;
            hold_d[i] = '0;
            mg_a[i]   = 1'b0;
            mg_b[i]   = 1'b0;
        end
        rq.delete();
    endtask

    task automatic model_eval();
        for (int i = 0; i < 2; i++) begin
            in_t         x = (i == 0) ? in0 : in1;
            out_t        o = (i == 0) ? o0 : o1;
            int          lat = (i == 0) ? LAT0 : LAT1;
            bit          rr = (i == 1);
            string       p = (i == 0) ? "u0" : "u1";
            bit          ga = 1'b0;
            bit          gb = 1'b0;
            bit          era = 1'b0;
            bit          erb = 1'b0;
            bit          stall;
            logic [31:0] edat = '0;
            logic [7:0]  eaddr;
            logic [31:0] edata;
            ret_t        r;
            if (rst_n) begin
                if (x.force_b) gb = x.b_req;
                else if (x.b_req && starve[i] >= LIMIT) gb = 1'b1;
                else if (x.a_req && x.b_req) begin
                    if (rr && last_a[i]) gb = 1'b1;
                    else ga = 1'b1;
                end else begin
                    ga = x.a_req;
                    gb = x.b_req;
                end
            end
            foreach (rq[k]) begin
                if (rq[k].inst == i && rq[k].due == cyc) begin
                    if (rq[k].own_b) erb = 1'b1;
                    else era = 1'b1;
                    edat = rq[k].data;
                end
            end
            stall = rst_n && x.a_req && !ga;
            eaddr = ga ? x.a_addr : (gb ? x.b_addr : hold_a[i]);
            edata = ga ? x.a_wdata : (gb ? 32'h0 : hold_d[i]);
            check({p, ".a_gnt"}, 32'(o.a_gnt), 32'(ga));
            check({p, ".b_gnt"}, 32'(o.b_gnt), 32'(gb));
            check({p, ".a_stall"}, 32'(o.a_stall), 32'(stall));
            check({p, ".mem_wren"}, 32'(o.mem_wren), 32'(ga && x.a_we));
            check({p, ".mem_address"}, 32'(o.mem_address), 32'(eaddr));
            check({p, ".mem_data"}, o.mem_data, edata);
            check({p, ".deny_cnt"}, 32'(o.deny_cnt), 32'(deny[i]));
            check({p, ".a_rvalid"}, 32'(o.a_rvalid), 32'(era));
            check({p, ".b_rvalid"}, 32'(o.b_rvalid), 32'(erb));
            if (era) check({p, ".a_rdata"}, o.a_rdata, edat);
            if (erb) check({p, ".b_rdata"}, o.b_rdata, edat);
            if (rst_n) begin
                if (gb || (ga && !x.a_we)) begin
                    r.inst  = i;
                    r.due   = cyc + lat;
                    r.own_b = gb;
                    r.data  = shadow[i][eaddr];
                    rq.push_back(r);
                end
                if (ga && x.a_we) shadow[i][x.a_addr] = x.a_wdata;
                if (ga || gb) begin
                    hold_a[i] = eaddr;
                    hold_d[i] = edata;
                    last_a[i] = ga;
                end
                if (x.b_req && !gb) starve[i] = (starve[i] < 255) ? starve[i] + 1 : 255;
                else starve[i] = 0;
                if (stall && deny[i] < 65535) deny[i]++;
            end
            mg_a[i] = ga;
            mg_b[i] = gb;
        end
        for (int k = rq.size() - 1; k >= 0; k--) if (rq[k].due <= cyc) rq.delete(k);
        cyc++;
    endtask

    task automatic half();
        @(negedge clk);
        if (!rst_n) model_reset();
        if (vec_on) begin
            check({"v.", cur_vec.name, ".a_gnt"}, 32'(ag0), 32'(cur_vec.a_gnt));
            check({"v.", cur_vec.name, ".b_gnt"}, 32'(bg0), 32'(cur_vec.b_gnt));
            check({"v.", cur_vec.name, ".mem_wren"}, 32'(mw0), 32'(cur_vec.wren));
            check({"v.", cur_vec.name, ".mem_address"}, 32'(ma0), 32'(cur_vec.addr));
            check({"v.", cur_vec.name, ".a_rvalid"}, 32'(arv0), 32'(cur_vec.arv));
            check({"v.", cur_vec.name, ".b_rvalid"}, 32'(brv0), 32'(cur_vec.brv));
            if (cur_vec.arv) check({"v.", cur_vec.name, ".a_rdata"}, ard0, cur_vec.rdata);
            if (cur_vec.brv) check({"v.", cur_vec.name, ".b_rdata"}, brd0, cur_vec.rdata);
        end
        model_eval();
    endtask

    task automatic rise();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        half();
        rise();
    endtask

    task automatic do_reset();
        in0   = '0;
        in1   = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic in_t mk_in(logic fb, logic ar, logic aw, logic [7:0] aa, logic [31:0] ad,
                                  logic br, logic [7:0] ba);
        return '{force_b: fb, a_req: ar, a_we: aw, a_addr: aa, a_wdata: ad, b_req: br, b_addr: ba};
    endfunction

    function automatic vec_t mk_vec(string nm, in_t x, bit ag, bit bg, bit wr, logic [7:0] ad,
                                    bit arv, bit brv, logic [31:0] rd);
        vec_t v;
        v.name = nm; v.in = x; v.a_gnt = ag; v.b_gnt = bg; v.wren = wr;
        v.addr = ad; v.arv = arv; v.brv = brv; v.rdata = rd;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ret_idx;
        logic [31:0] want;

        for (int i = 0; i < 2; i++) for (int k = 0; k < 256; k++) shadow[i][k] = init_word(k);
        model_reset();

        tbl[0] = mk_vec("wr05",  mk_in(1'b0, 1'b1, 1'b1, 8'h05, 32'hDEADBEEF, 1'b0, 8'h00), 1'b1, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 32'h0);
        tbl[1] = mk_vec("rd05",  mk_in(1'b0, 1'b1, 1'b0, 8'h05, 32'h0, 1'b0, 8'h00),        1'b1, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0, 32'h0);
        tbl[2] = mk_vec("ret05", '0,                                                          1'b0, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0, 32'hDEADBEEF);
        tbl[3] = mk_vec("wr3c",  mk_in(1'b0, 1'b1, 1'b1, 8'h3C, 32'h12345678, 1'b0, 8'h00), 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 32'h0);
        tbl[4] = mk_vec("hold1", '0,                                                          1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 32'h0);
        tbl[5] = mk_vec("hold2", '0,                                                          1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 32'h0);
        tbl[6] = mk_vec("brd3c", mk_in(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 8'h3C),        1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 32'h0);
        tbl[7] = mk_vec("bret",  '0,                                                          1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 32'h12345678);

        // Power-on reset state
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        half();
        check("rst.a_gnt", 32'(ag0), 32'h0);
        check("rst.mem_wren", 32'(mw0), 32'h0);
        check("rst.mem_address", 32'(ma0), 32'h0);
        check("rst.mem_data", md0, 32'h0);
        check("rst.deny_cnt", 32'(dc1), 32'h0);
        rise();
        rst_n = 1'b1;

        // Directed table: A write/read, idle hold, B read
        vec_on = 1'b1;
        for (int v = 0; v < 8; v++) begin
            in0     = tbl[v].in;
            cur_vec = tbl[v];
            tick();
        end
        vec_on = 1'b0;
        in0    = '0;

        // Reset arriving while an A read is in flight
        in0 = mk_in(1'b0, 1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 8'h00);
        half();
        check("midrst.a_gnt", 32'(ag0), 32'h1);
        rise();
        rst_n = 1'b0;
        in0   = '0;
        half();
        check("midrst.a_rvalid", 32'(arv0), 32'h0);
        check("midrst.mem_address", 32'(ma0), 32'h0);
        check("midrst.mem_data", md0, 32'h0);
        check("midrst.deny_cnt", 32'(dc0), 32'h0);
        rise();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            half();
            check("midrst.no_rvalid", 32'(arv0 | brv0), 32'h0);
            rise();
        end

        // Contention with A priority: B forced in after STARVE_LIMIT denials
        do_reset();
        for (int c = 1; c <= 17; c++) begin
            in0 = mk_in(1'b0, 1'b1, 1'b0, 8'(c == 17 ? 16 : c), 32'h0, 1'b1, 8'h20);
            half();
            check("starve.a_gnt", 32'(ag0), 32'(c != 16));
            check("starve.b_gnt", 32'(bg0), 32'(c == 16));
            if (c == 17) check("starve.deny_cnt", 32'(dc0), 32'h1);
            rise();
        end
        in0 = '0;
        tick();

        // force_b: only B served, A stalls, B reads come back in order
        do_reset();
        ret_idx = 0;
        for (int k = 0; k < 11; k++) begin
            in0 = (k < 10) ? mk_in(1'b1, 1'b1, 1'b0, 8'h40, 32'h0, 1'b1, 8'(k)) : '0;
            half();
            if (k < 10) begin
                check("force.a_gnt", 32'(ag0), 32'h0);
                check("force.a_stall", 32'(as0), 32'h1);
                check("force.b_gnt", 32'(bg0), 32'h1);
            end else begin
                check("force.deny_cnt", 32'(dc0), 32'd10);
            end
            if (brv0) begin
                want = (ret_idx == 5) ? 32'hDEADBEEF : init_word(ret_idx);
                check("force.b_order", brd0, want);
                ret_idx++;
            end
            rise();
        end
        check("force.b_returns", 32'(ret_idx), 32'd10);

        // Round robin with MEM_LAT=2: alternate grants, each rvalid on its own port
        do_reset();
        begin
            int ac = 0;
            int bc = 0;
            for (int c = 0; c < 10; c++) begin
                in1 = mk_in(1'b0, 1'b1, 1'b0, 8'(8'h80 + ac), 32'h0, 1'b1, 8'(8'hC0 + bc));
                half();
                check("rr.a_gnt", 32'(ag1), 32'(c % 2 == 0));
                check("rr.b_gnt", 32'(bg1), 32'(c % 2 == 1));
                if (c >= 2) begin
                    check("rr.a_rvalid", 32'(arv1), 32'(c % 2 == 0));
                    check("rr.b_rvalid", 32'(brv1), 32'(c % 2 == 1));
                end
                rise();
                if (c % 2 == 0) ac++;
                else bc++;
            end
            in1 = '0;
        end

        // Random traffic on both instances against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            for (int i = 0; i < 2; i++) begin
                in_t x = (i == 0) ? in0 : in1;
                if (!x.a_req || mg_a[i]) begin
                    x.a_req   = ($urandom_range(0, 99) < 60);
                    x.a_we    = 1'($urandom_range(0, 1));
                    x.a_addr  = 8'($urandom_range(0, 31));
                    x.a_wdata = $urandom;
                end
                if (!x.b_req || mg_b[i]) begin
                    x.b_req  = ($urandom_range(0, 99) < 45);
                    x.b_addr = 8'($urandom_range(0, 31));
                end
                if ($urandom_range(0, 99) < 4) x.force_b = ~x.force_b;
                if (i == 0) in0 = x;
                else in1 = x;
            end
            tick();
        end
        in0 = '0;
        in1 = '0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
